// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle mult/div sequencer (radix-2 shift-add / restoring), HI/LO results; `MULDIV_SIGNED_EN adds signed operation
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0] nxt_hi, nxt_lo, res_hi, res_lo, mag_a, mag_b;
  logic [WIDTH:0] mul_sum, div_shift, div_diff;
  logic is_mul, is_div, accept, b_zero;
  assign is_mul = alu_op == OP_MULT;
  assign is_div = alu_op == OP_DIV;
  assign b_zero = operand_b == '0;
  assign accept = start && state == IDLE && (is_mul || is_div);
  assign stall  = busy || accept;
  // acc_hi:acc_lo is the product accumulator (mult) or remainder:shifting dividend (div)
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, acc_lo[0] ? opnd : '0};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    nxt_hi    = state == MUL ? mul_sum[WIDTH:1]
              : div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    nxt_lo    = state == MUL ? {mul_sum[0], acc_lo[WIDTH-1:1]}
              : {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
  end
`ifdef MULDIV_SIGNED_EN
  logic neg_hi, neg_lo;
  logic [2*WIDTH-1:0] prod_neg;
  always_comb begin
    mag_a    = operand_a[WIDTH-1] ? -operand_a : operand_a;
    mag_b    = operand_b[WIDTH-1] ? -operand_b : operand_b;
    prod_neg = -{nxt_hi, nxt_lo};
    res_hi   = !neg_hi ? nxt_hi : state == MUL ? prod_neg[2*WIDTH-1:WIDTH] : -nxt_hi;
    res_lo   = !neg_lo ? nxt_lo : state == MUL ? prod_neg[WIDTH-1:0] : -nxt_lo;
  end
  // mult negates the whole product on sign mismatch; div remainder follows the dividend sign
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
    end else if (accept) begin
      neg_lo <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      neg_hi <= is_mul ? operand_a[WIDTH-1] ^ operand_b[WIDTH-1] : operand_a[WIDTH-1];
    end
  end
`else
  always_comb begin
    mag_a  = operand_a;
    mag_b  = operand_b;
    res_hi = nxt_hi;
    res_lo = nxt_lo;
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          div_by_zero <= is_div && b_zero;
          cnt         <= CW'(WIDTH);
          acc_hi      <= '0;
          acc_lo      <= is_mul ? mag_b : mag_a;
          opnd        <= is_mul ? mag_a : mag_b;
          if (is_div && b_zero) begin
            hi    <= operand_a;
            lo    <= '1;
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= is_mul ? MUL : DIV;
            busy  <= 1'b1;
          end
        end
        MUL, DIV: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
